// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator CPU.
// Holds the ISA opcode values, the ALU operation codes (also used by the ALU),
// the sequencer state encoding and the decoded-control bundle.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OPC_W  = 4;

  // ISA opcodes, IR[15:12]
  localparam logic [OPC_W-1:0] OP_NOP    = 4'h0;
  localparam logic [OPC_W-1:0] OP_LOAD   = 4'h1;
  localparam logic [OPC_W-1:0] OP_STORE  = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD    = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB    = 4'h4;
  localparam logic [OPC_W-1:0] OP_AND    = 4'h5;
  localparam logic [OPC_W-1:0] OP_OR     = 4'h6;
  localparam logic [OPC_W-1:0] OP_XOR    = 4'h7;
  localparam logic [OPC_W-1:0] OP_SHL    = 4'h8;
  localparam logic [OPC_W-1:0] OP_SHR    = 4'h9;
  localparam logic [OPC_W-1:0] OP_JUMP   = 4'hA;
  localparam logic [OPC_W-1:0] OP_JZ     = 4'hB;
  localparam logic [OPC_W-1:0] OP_LOADI  = 4'hC;
  localparam logic [OPC_W-1:0] OP_RSVD_D = 4'hD;
  localparam logic [OPC_W-1:0] OP_RSVD_E = 4'hE;
  localparam logic [OPC_W-1:0] OP_HALT   = 4'hF;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SHL = 4'b0100;
  localparam logic [3:0] ALU_SHR = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_FWAIT  = 3'd2,
    S_DECODE = 3'd3,
    S_OPWAIT = 3'd4,
    S_HALTED = 3'd5
  } state_e;

  // Decoded control for one instruction
  typedef struct packed {
    logic       needs_mem;   // reads M[a] in OPWAIT
    logic       is_store;
    logic       writes_acc;
    logic       uses_alu;    // ACC takes alu_result rather than a load value
    logic       is_jump;
    logic       is_jz;
    logic       is_halt;
    logic       is_illegal;
    logic [3:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/cpu_instr_decode.sv
// Combinational instruction decoder.
// Ports:
//   opcode_i : IR[15:12]
//   ctrl_o   : decoded control bundle (ctrl_t)
module cpu_instr_decode
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output ctrl_t            ctrl_o
);

  // Opcode to control mapping; NOP leaves everything cleared
  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      OP_NOP: ;
      OP_LOAD: begin
        ctrl_o.needs_mem  = 1'b1;
        ctrl_o.writes_acc = 1'b1;
      end
      OP_STORE: ctrl_o.is_store = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        ctrl_o.needs_mem  = 1'b1;
        ctrl_o.writes_acc = 1'b1;
        ctrl_o.uses_alu   = 1'b1;
        case (opcode_i)
          OP_SUB:  ctrl_o.alu_op = ALU_SUB;
          OP_AND:  ctrl_o.alu_op = ALU_AND;
          OP_OR:   ctrl_o.alu_op = ALU_OR;
          OP_XOR:  ctrl_o.alu_op = ALU_XOR;
          default: ctrl_o.alu_op = ALU_ADD;
        endcase
      end
      OP_SHL, OP_SHR: begin
        ctrl_o.writes_acc = 1'b1;
        ctrl_o.uses_alu   = 1'b1;
        ctrl_o.alu_op     = (opcode_i == OP_SHL) ? ALU_SHL : ALU_SHR;
      end
      OP_JUMP:  ctrl_o.is_jump    = 1'b1;
      OP_JZ:    ctrl_o.is_jz      = 1'b1;
      OP_LOADI: ctrl_o.writes_acc = 1'b1;
      OP_RSVD_D, OP_RSVD_E: ctrl_o.is_illegal = 1'b1;
      OP_HALT:  ctrl_o.is_halt    = 1'b1;
      default:  ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// Owns PC, IR, MBR and ACC, drives the synchronous memory port and the
// shared combinational ALU.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   run                   : start/continue, sampled in IDLE and at instruction ends
//   mem_addr/mem_wdata/mem_we/mem_rdata : memory port (read data one cycle late)
//   alu_op/alu_a/alu_b/alu_result       : ALU interface (alu_a is ACC)
//   acc_out/pc_out/ir_out : architectural register views
//   halted                : high in HALTED
//   illegal_op            : one-cycle pulse after decoding a reserved opcode
module cpu_control_sequencer
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter int unsigned OPERAND_WIDTH = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] acc_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] ir_out,
  output logic              halted,
  output logic              illegal_op
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mbr_q, mbr_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;

  ctrl_t             ctrl;
  logic [DATA_W-1:0] operand;
  state_e            boundary_state;

  // IR loads from memory in FWAIT. Decoding the next IR value lets the
  // registered outputs for DECODE be ready on the edge that enters it.
  assign ir_d    = (state_q == S_FWAIT) ? mem_rdata : ir_q;
  assign operand = DATA_W'(ir_d[OPERAND_WIDTH-1:0]);

  cpu_instr_decode u_decode (
    .opcode_i (ir_d[DATA_W-1 -: OPC_W]),
    .ctrl_o   (ctrl)
  );

  // MBR captures the operand word in OPWAIT
  always_comb begin
    mbr_d = mbr_q;
    if (state_q == S_OPWAIT) begin
      mbr_d = mem_rdata;
    end
  end

  // Operand data only arrives in the OPWAIT cycle itself, so alu_b cannot
  // be registered ahead of time.
  assign alu_b = (state_q == S_OPWAIT) ? mbr_d : '0;

  // Next-state, register updates and next values of the registered outputs
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    acc_d          = acc_q;
    illegal_d      = 1'b0;
    boundary_state = run ? S_FETCH : S_IDLE;

    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_FWAIT;
      S_FWAIT: begin
        pc_d    = DATA_W'(pc_q + 16'd1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (ctrl.needs_mem) begin
          state_d = S_OPWAIT;
        end else if (ctrl.is_halt) begin
          state_d = S_HALTED;
        end else begin
          state_d = boundary_state;
        end
        // Shifts and LOADI complete here; memory-operand ops finish in OPWAIT
        if (ctrl.writes_acc && !ctrl.needs_mem) begin
          acc_d = ctrl.uses_alu ? alu_result : operand;
        end
        if (ctrl.is_jump || (ctrl.is_jz && (acc_q == '0))) begin
          pc_d = operand;
        end
        illegal_d = ctrl.is_illegal;
      end
      S_OPWAIT: begin
        acc_d   = ctrl.uses_alu ? alu_result : mbr_d;
        state_d = boundary_state;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase

    // Output values for the state being entered
    mem_we_d   = (state_d == S_DECODE) && ctrl.is_store;
    mem_addr_d = ((state_d == S_DECODE) || (state_d == S_OPWAIT)) ? operand : pc_d;
    alu_op_d   = ALU_ADD;
    if ((state_d == S_OPWAIT) ||
        ((state_d == S_DECODE) && ctrl.uses_alu && !ctrl.needs_mem)) begin
      alu_op_d = ctrl.alu_op;
    end
    halted_d = (state_d == S_HALTED);
  end

  // State and register bank; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      mbr_q      <= '0;
      acc_q      <= '0;
      mem_addr_q <= RESET_PC;
      mem_we_q   <= 1'b0;
      alu_op_q   <= ALU_ADD;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      mbr_q      <= mbr_d;
      acc_q      <= acc_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      alu_op_q   <= alu_op_d;
      halted_q   <= halted_d;
      illegal_q  <= illegal_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = acc_q;
  assign mem_we     = mem_we_q;
  assign alu_op     = alu_op_q;
  assign alu_a      = acc_q;
  assign acc_out    = acc_q;
  assign pc_out     = pc_q;
  assign ir_out     = ir_q;
  assign halted     = halted_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed bench for cpu_control_sequencer with a synchronous memory model,
// an ALU model and a scoreboard of expected memory writes.
module tb_cpu_control_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [15:0] acc_out, pc_out, ir_out;
  logic        halted, illegal_op;

  int checks = 0;
  int errors = 0;
  int we_cycles = 0;
  int illegal_cycles = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;
  wr_t exp_wr_q[$];

  logic [15:0] mem [0:65535];
  logic        tb_we;
  logic [15:0] tb_waddr, tb_wdata;

  cpu_control_sequencer #(
    .RESET_PC      (16'h0000),
    .OPERAND_WIDTH (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .acc_out    (acc_out),
    .pc_out     (pc_out),
    .ir_out     (ir_out),
    .halted     (halted),
    .illegal_op (illegal_op)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous memory: registered read data, bench preload port
  always @(posedge clk) begin
    if (tb_we) mem[tb_waddr] <= tb_wdata;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // ALU reference
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0100: alu_result = alu_a << 1;
      4'b0101: alu_result = alu_a >> 1;
      4'b1000: alu_result = alu_a & alu_b;
      4'b1001: alu_result = alu_a | alu_b;
      4'b1010: alu_result = alu_a ^ alu_b;
      default: alu_result = 16'h0000;
    endcase
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory writes are popped from the scoreboard as the DUT issues them
  always @(negedge clk) begin
    if (illegal_op === 1'b1) illegal_cycles++;
    if (mem_we === 1'b1) begin
      we_cycles++;
      checks++;
      assert (exp_wr_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed addr=%h data=%h expected no write", mem_addr, mem_wdata);
      end
      if (exp_wr_q.size() != 0) begin
        wr_t w;
        w = exp_wr_q.pop_front();
        check("wr_addr", mem_addr, w.addr);
        check("wr_data", mem_wdata, w.data);
      end
    end
  end

  task automatic load_word(input logic [15:0] a, input logic [15:0] d);
    tb_we    = 1'b1;
    tb_waddr = a;
    tb_wdata = d;
    @(negedge clk);
    tb_we    = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_acc"},     acc_out, 16'h0000);
    check({tag, "_pc"},      pc_out, 16'h0000);
    check({tag, "_ir"},      ir_out, 16'h0000);
    check({tag, "_addr"},    mem_addr, 16'h0000);
    check({tag, "_we"},      16'(mem_we), 16'h0000);
    check({tag, "_halted"},  16'(halted), 16'h0000);
    check({tag, "_illegal"}, 16'(illegal_op), 16'h0000);
    check({tag, "_aluop"},   16'(alu_op), 16'h0000);
    check({tag, "_alub"},    alu_b, 16'h0000);
  endtask

  // Reset asserted mid-cycle (at the falling edge), checked before any clock
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b0;
    #1;
    check_reset_values("rst_pulse");
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Wait for halted with a cycle budget; the count itself is compared
  task automatic wait_halt(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while ((halted !== 1'b1) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 16'(n), 16'(exp_cycles));
  endtask

  initial begin
    reset    = 1'b1;
    run      = 1'b0;
    tb_we    = 1'b0;
    tb_waddr = 16'h0000;
    tb_wdata = 16'h0000;
    repeat (2) @(negedge clk);
    check_reset_values("por");
    reset = 1'b0;

    // Program: LOAD 0x10; ADD 0x11; STORE 0x12; HALT
    load_word(16'h0000, 16'h1010);
    load_word(16'h0001, 16'h3011);
    load_word(16'h0002, 16'h2012);
    load_word(16'h0003, 16'hF000);
    load_word(16'h0010, 16'h0005);
    load_word(16'h0011, 16'h0007);
    load_word(16'h0012, 16'h0000);
    check("idle_pc", pc_out, 16'h0000);
    check("idle_ir", ir_out, 16'h0000);
    exp_wr_q.push_back('{addr: 16'h0012, data: 16'h000C});
    run = 1'b1;
    wait_halt("prog_halt_latency", 1 + 14);
    check("prog_pc", pc_out, 16'h0004);
    check("prog_acc", acc_out, 16'h000C);
    check("prog_mem12", mem[16'h0012], 16'h000C);
    check("prog_we_cycles", 16'(we_cycles), 16'd1);
    check("prog_sb_empty", 16'(exp_wr_q.size()), 16'd0);
    run = 1'b0;
    repeat (3) @(negedge clk);
    check("halted_sticky", 16'(halted), 16'd1);
    check("halted_pc", pc_out, 16'h0004);

    // JZ taken then not taken
    do_reset();
    load_word(16'h0000, 16'hC000);
    load_word(16'h0001, 16'hB020);
    load_word(16'h0020, 16'hC001);
    load_word(16'h0021, 16'hB030);
    load_word(16'h0022, 16'hF000);
    run = 1'b1;
    repeat (7) @(negedge clk);
    check("jz_taken_pc", pc_out, 16'h0020);
    check("jz_taken_addr", mem_addr, 16'h0020);
    check("jz_taken_acc", acc_out, 16'h0000);
    repeat (6) @(negedge clk);
    check("jz_not_taken_pc", pc_out, 16'h0022);
    check("jz_not_taken_acc", acc_out, 16'h0001);
    wait_halt("jz_halt_latency", 3);
    check("jz_final_pc", pc_out, 16'h0023);

    // Reserved opcode at PC=5
    do_reset();
    illegal_cycles = 0;
    load_word(16'h0000, 16'hC077);
    load_word(16'h0001, 16'hA005);
    load_word(16'h0005, 16'hD123);
    load_word(16'h0006, 16'hF000);
    run = 1'b1;
    repeat (7) @(negedge clk);
    check("jump_pc", pc_out, 16'h0005);
    check("jump_addr", mem_addr, 16'h0005);
    repeat (3) @(negedge clk);
    check("illegal_pulse", 16'(illegal_op), 16'd1);
    check("illegal_acc", acc_out, 16'h0077);
    check("illegal_pc", pc_out, 16'h0006);
    check("illegal_next_fetch", mem_addr, 16'h0006);
    @(negedge clk);
    check("illegal_drop", 16'(illegal_op), 16'd0);
    wait_halt("illegal_halt_latency", 2);
    check("illegal_cycles", 16'(illegal_cycles), 16'd1);
    check("illegal_final_pc", pc_out, 16'h0007);

    // Reset during OPWAIT of ADD
    do_reset();
    load_word(16'h0000, 16'hC003);
    load_word(16'h0001, 16'h3010);
    load_word(16'h0010, 16'h0005);
    run = 1'b1;
    repeat (7) @(negedge clk);
    check("opwait_alub", alu_b, 16'h0005);
    check("opwait_acc_before", acc_out, 16'h0003);
    reset = 1'b1;
    run   = 1'b0;
    #1;
    check("abort_acc", acc_out, 16'h0000);
    check("abort_pc", pc_out, 16'h0000);
    check("abort_we", 16'(mem_we), 16'd0);
    check("abort_addr", mem_addr, 16'h0000);
    @(negedge clk);
    check("abort_no_acc_write", acc_out, 16'h0000);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_idle_pc", pc_out, 16'h0000);

    // run dropped during DECODE of LOADI 0x055
    do_reset();
    load_word(16'h0000, 16'hC055);
    load_word(16'h0001, 16'hC066);
    load_word(16'h0002, 16'hF000);
    run = 1'b1;
    repeat (3) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    check("rundrop_acc", acc_out, 16'h0055);
    check("rundrop_pc", pc_out, 16'h0001);
    check("rundrop_addr", mem_addr, 16'h0001);
    repeat (3) @(negedge clk);
    check("rundrop_idle_pc", pc_out, 16'h0001);
    check("rundrop_idle_ir", ir_out, 16'hC055);
    run = 1'b1;
    repeat (4) @(negedge clk);
    check("resume_acc", acc_out, 16'h0066);
    check("resume_pc", pc_out, 16'h0002);
    wait_halt("resume_halt_latency", 3);

    // ALU mix: LOADI, OR, SHL, SUB (wraps), XOR, AND, STORE, SHR, HALT
    do_reset();
    load_word(16'h0000, 16'hC0F0);
    load_word(16'h0001, 16'h6010);
    load_word(16'h0002, 16'h8000);
    load_word(16'h0003, 16'h4011);
    load_word(16'h0004, 16'h7012);
    load_word(16'h0005, 16'h5013);
    load_word(16'h0006, 16'h2014);
    load_word(16'h0007, 16'h9000);
    load_word(16'h0008, 16'hF000);
    load_word(16'h0010, 16'h000F);
    load_word(16'h0011, 16'h0200);
    load_word(16'h0012, 16'hFFFF);
    load_word(16'h0013, 16'h0003);
    load_word(16'h0014, 16'h0000);
    exp_wr_q.push_back('{addr: 16'h0014, data: 16'h0001});
    run = 1'b1;
    wait_halt("alu_halt_latency", 32);
    check("alu_acc", acc_out, 16'h0000);
    check("alu_pc", pc_out, 16'h0009);
    check("alu_mem14", mem[16'h0014], 16'h0001);
    check("alu_we_cycles", 16'(we_cycles), 16'd2);
    check("alu_sb_empty", 16'(exp_wr_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
